// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests, small in-order instruction buffer,
// redirect flush with stale-response discard. Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [2:0]  type_o,
  output logic        misalign_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_FETCH, S_FULL, S_DISCARD, S_HALT} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_pc;
  logic [31:0]      r_stale_addr;
  logic             r_halt_pend;
  logic [31:0]      r_fifo_inst [FIFO_DEPTH];
  logic [31:0]      r_fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_trap;
  logic [31:0]      w_target;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_after;

  assign w_empty       = (r_count == '0);
  assign w_trap        = TRAP_EN && redirect && (redirect_pc[1:0] != 2'b00);
  assign w_target      = {redirect_pc[31:2], 2'b00};
  assign w_push        = (r_state == S_FETCH) && imem_ack && !redirect;
  assign w_pop         = inst_valid && inst_ready && !redirect;
  assign w_count_after = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_next;
  end

  // NOTE: default assignment first so no path through this block can infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_FETCH: begin
        if (redirect) begin
          if (!imem_ack) w_state_next = S_DISCARD;
          else           w_state_next = w_trap ? S_HALT : S_FETCH;
        end else if (imem_ack && (w_count_after == CNT_W'(FIFO_DEPTH))) begin
          w_state_next = S_FULL;
        end
      end
      S_FULL: begin
        if (redirect)   w_state_next = w_trap ? S_HALT : S_FETCH;
        else if (w_pop) w_state_next = S_FETCH;
      end
      S_DISCARD: begin
        // The stale response must arrive before the newest target can be requested.
        if (imem_ack) begin
          if (redirect) w_state_next = w_trap ? S_HALT : S_FETCH;
          else          w_state_next = r_halt_pend ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        if (redirect && !w_trap) w_state_next = S_FETCH;
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req   = !rst && ((r_state == S_FETCH) || (r_state == S_DISCARD));
    imem_addr  = (r_state == S_DISCARD) ? r_stale_addr : r_pc;
    inst_valid = !rst && !w_empty;
    inst_out   = w_empty ? 32'h0 : r_fifo_inst[r_rd_ptr];
    pc_out     = w_empty ? 32'h0 : r_fifo_pc[r_rd_ptr];
  end

  always_comb begin
    type_o = 3'd0;
    unique case (inst_out[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: type_o = 3'd1;
      7'b0100011:                                     type_o = 3'd2;
      7'b1100011:                                     type_o = 3'd3;
      7'b1101111:                                     type_o = 3'd4;
      7'b0110111, 7'b0010111:                         type_o = 3'd5;
      default:                                        type_o = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_stale_addr <= RESET_PC;
      r_halt_pend  <= 1'b0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
    end else if (redirect) begin
      r_pc        <= w_target;
      r_halt_pend <= w_trap;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      if ((r_state == S_FETCH) && !imem_ack) r_stale_addr <= r_pc;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + 32'd4;
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_after;
    end
  end

  // NOTE: buffer storage has no reset; entries are only visible once the occupancy count covers them.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_fifo_inst[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]   <= r_pc;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;

  always_ff @(posedge clk) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= w_trap;
  end

  assign misalign_o = r_misalign && !rst;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of instruction buffer entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning the reset, which is synchronous and active-high.
REQ-005 SHALL have port imem_req, output, 1, meaning the instruction memory read request.
REQ-006 SHALL have port imem_addr, output, 32, meaning the word-aligned fetch address.
REQ-007 SHALL have port imem_ack, input, 1, meaning the memory has imem_rdata valid this cycle for the held request.
REQ-008 SHALL have port imem_rdata, input, 32, meaning the fetched instruction.
REQ-009 SHALL have port redirect, input, 1, meaning a taken branch or jump this cycle.
REQ-010 SHALL have port redirect_pc, input, 32, meaning the branch/jump target.
REQ-011 SHALL have port inst_valid, output, 1, meaning inst_out, pc_out and type_o are valid.
REQ-012 SHALL have port inst_ready, input, 1, meaning decode accepts the head entry.
REQ-013 SHALL have port inst_out, output, 32, meaning the head instruction, which feeds the immediate generator inst input.
REQ-014 SHALL have port pc_out, output, 32, meaning the address of inst_out.
REQ-015 SHALL have port type_o, output, 3, meaning the immediate format of inst_out (I=1, S=2, SB=3, UJ=4, U=5, none=0), which feeds the immediate generator type_i input.
REQ-016 SHALL have port misalign_o, output, 1, meaning a one-cycle pulse on a misaligned redirect.

Function
REQ-017 SHALL implement FSM states FETCH (req asserted, awaiting ack), FULL (buffer has no free slot, req low), DISCARD (stale request outstanding) and HALT (fetch stopped).
REQ-018 SHALL hold imem_req high and imem_addr stable from assertion until imem_ack, with at most one request outstanding.
REQ-019 SHALL, on imem_ack in FETCH, push {imem_rdata, imem_addr} and advance fetch PC by 4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-020 SHALL issue the next request in the cycle after ack if a slot is free, counting a same-cycle pop as freeing a slot; otherwise SHALL enter FULL and leave it on the first pop.
REQ-021 SHALL pop the head when inst_valid and inst_ready are both high; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-022 SHALL decode type_o combinationally from inst_out[6:0]: 0000011/0010011/1100111/1110011 -> 1; 0100011 -> 2; 1100011 -> 3; 1101111 -> 4; 0110111/0010111 -> 5; other -> 0.
REQ-023 SHALL, on redirect, flush the buffer in the same cycle, set fetch PC to redirect_pc with bits [1:0] cleared, and give redirect priority over push, pop and ack.
REQ-024 SHALL, on a redirect while a request is outstanding without same-cycle ack, enter DISCARD, hold the old request until ack, drop its data, then request the new PC.
REQ-025 SHALL make the first redirected instruction available on inst_valid no earlier than 2 cycles after redirect with single-cycle ack; there is no bypass from imem_rdata to inst_out.
REQ-026 SHALL, on a second redirect while in DISCARD, keep only the latest target.

Reset
REQ-027 SHALL, on rst, empty the buffer, set fetch PC=RESET_PC and state=FETCH, and drive inst_valid=0, misalign_o=0, imem_req=0 during the reset cycle.
REQ-028 SHALL give rst priority over redirect, and SHALL treat rst during an outstanding request as abandoning it, ignoring any ack in the reset cycle.
REQ-029 SHALL drive inst_out=0, pc_out=0, type_o=0 whenever the buffer is empty.

Configuration
REQ-030 SHALL, with FETCH_MISALIGN_TRAP_EN defined, treat a redirect with redirect_pc[1:0]!=0 as follows: pulse misalign_o for one cycle, flush the buffer, and enter HALT (req low, still honouring REQ-024 for an outstanding request); HALT exits only on an aligned redirect.
REQ-031 SHALL, without FETCH_MISALIGN_TRAP_EN, tie misalign_o to 0 and handle every redirect per REQ-023.

Verification
REQ-032 SHALL cover reset then free-running 1-cycle ack with inst_ready=1: imem_addr sequence 0,4,8; pc_out 0,4,8 with matching inst_out.
REQ-033 SHALL cover inst_ready=0 for 10 cycles: exactly 2 accepted fetches, imem_req low, FSM=FULL; one pop -> request for address 8 issued the next cycle.
REQ-034 SHALL cover redirect to 32'h100 while a request to 0x8 waits 3 cycles for ack: 0x8 data never appears; the next pc_out is 32'h100; type_o matches opcode (1100011 -> 3).
REQ-035 SHALL cover a fetch PC of 32'hFFFF_FFFC: the next request goes to 32'h0000_0000.
REQ-036 SHALL cover, with the macro, a redirect to 32'h102: misalign_o=1 for one cycle and no requests; a redirect to 32'h200 then resumes fetch at 0x200. Without the macro, the same stimulus fetches 0x100.
